// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
//
// Shares one main-memory port between the I-side and D-side cache miss
// handlers. One requester is granted at a time for a whole cache line. The
// block walks the line beat by beat, presents each word address to memory,
// steers read data and write acceptance back to the granted side, and ends
// the transfer with a one-cycle done pulse to that side.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  When defined, a tie in IDLE goes to the side that
//                       was not granted last. When undefined, D always wins
//                       a tie (fixed priority).
//
// Ports:
//   clk, rst_n          core clock; asynchronous active-low reset
//   ic_req, ic_addr     I-side line read request and line address
//   ic_rdata, ic_rvalid I-side read beat data and its qualifier
//   ic_done             I-side transfer complete pulse
//   dc_req, dc_we       D-side line request; 1 = writeback, 0 = refill
//   dc_addr, dc_wdata   D-side line address and current writeback word
//   dc_wready           D-side writeback word consumed this cycle
//   dc_rdata, dc_rvalid D-side read beat data and its qualifier
//   dc_done             D-side transfer complete pulse
//   mem_req, mem_we     memory beat request and direction
//   mem_addr, mem_wdata memory beat word address and write data
//   mem_rdata, mem_ack  memory read data and beat completion
//   dbg_state           current FSM state, for observation only
//
// Handshake: a beat is in flight while mem_req is high and completes in
// the cycle mem_ack is high. mem_addr and mem_we stay stable until that
// cycle. ic_rvalid / dc_rvalid / dc_wready are the same-cycle echo of
// mem_ack towards the granted side, so a requester advances exactly once
// per completed beat.

module mem_refill_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  // 0 = I-side, 1 = D-side. Also tells DONE which side to pulse.
  logic                last_grant_q, last_grant_d;

  logic                tie_pick_d;
  logic                pick_d;
  logic                in_grant_i;
  logic                in_grant_d;

  // Winner when both sides request in the same IDLE cycle.
`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick_d = ~last_grant_q;
`else
  assign tie_pick_d = 1'b1;
`endif

  // 1 selects D: D alone, or a tie resolved towards D.
  assign pick_d = dc_req & (~ic_req | tie_pick_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      we_q         <= 1'b0;
      beat_q       <= '0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      we_q         <= we_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    we_d         = we_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          beat_d       = '0;
          last_grant_d = pick_d;
          if (pick_d) begin
            state_d = S_GRANT_D;
            base_d  = dc_addr & ~OFF_MASK;
            we_d    = dc_we;
          end else begin
            state_d = S_GRANT_I;
            base_d  = ic_addr & ~OFF_MASK;
            we_d    = 1'b0;
          end
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (mem_ack) begin
          // The counter stops on the last beat instead of wrapping; IDLE
          // clears it before the next line.
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_grant_i = (state_q == S_GRANT_I);
  assign in_grant_d = (state_q == S_GRANT_D);

  // Everything towards memory derives from registered state, so an
  // asynchronous reset drops mem_req without waiting for a clock edge.
  assign mem_req   = in_grant_i | in_grant_d;
  assign mem_we    = in_grant_d & we_q;
  assign mem_addr  = base_q + ADDR_W'({beat_q, 2'b00});
  assign mem_wdata = dc_wdata;

  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign ic_rvalid = in_grant_i & mem_ack;
  assign dc_rvalid = in_grant_d & mem_ack & ~we_q;
  assign dc_wready = in_grant_d & mem_ack & we_q;

  assign ic_done   = (state_q == S_DONE) & ~last_grant_q;
  assign dc_done   = (state_q == S_DONE) &  last_grant_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: line transfers for both sides against a
// transaction-level model of line addresses, beat kinds, arbitration order
// and cycle timing.

module tb_mem_refill_arbiter;

  localparam int LW = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          ic_rvalid;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_wready;
  logic [DW-1:0] dc_rdata;
  logic          dc_rvalid;
  logic          dc_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    dbg_state;

  mem_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wready(dc_wready), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
    .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  int cyc;
  int spur;
  int dc_extra;

  // Beat kinds: 0 = I read, 1 = D read, 2 = D write, 3 = malformed.
  logic [AW-1:0] exp_q[$];
  logic [1:0]    exp_kind_q[$];
  logic [AW-1:0] beat_addr_q[$];
  logic [1:0]    beat_kind_q[$];
  int            beat_cyc_q[$];
  bit            beat_ok_q[$];
  bit            done_side_q[$];
  int            done_cyc_q[$];

  // ---------------- monitor (samples at negedge) ----------------
  initial begin
    logic [1:0] kind;
    cyc  = 0;
    spur = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req && mem_ack) begin
        if (ic_rvalid && !dc_rvalid && !dc_wready && !mem_we)      kind = 2'd0;
        else if (dc_rvalid && !ic_rvalid && !dc_wready && !mem_we) kind = 2'd1;
        else if (dc_wready && !ic_rvalid && !dc_rvalid && mem_we)  kind = 2'd2;
        else                                                       kind = 2'd3;
        beat_addr_q.push_back(mem_addr);
        beat_kind_q.push_back(kind);
        beat_cyc_q.push_back(cyc);
        beat_ok_q.push_back((ic_rdata === mem_rdata) && (dc_rdata === mem_rdata) &&
                            (mem_wdata === dc_wdata));
      end else if (ic_rvalid || dc_rvalid || dc_wready) begin
        spur++;
      end
      if (ic_done) begin done_side_q.push_back(1'b0); done_cyc_q.push_back(cyc); end
      if (dc_done) begin done_side_q.push_back(1'b1); done_cyc_q.push_back(cyc); end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = AW'(LW * 4 - 1);
    return a & ~m;
  endfunction

  // Returns 1 when D wins the IDLE decision.
  function automatic bit arb_d(input bit ic, input bit dc, input bit last_was_d);
    if (ic && dc) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_was_d;
`else
      return 1'b1;
`endif
    end
    return dc;
  endfunction

  task automatic model_line(input bit side_d, input bit we, input logic [AW-1:0] a);
    for (int k = 0; k < LW; k++) begin
      exp_q.push_back(line_base(a) + AW'(4 * k));
      exp_kind_q.push_back(side_d ? (we ? 2'd2 : 2'd1) : 2'd0);
    end
  endtask

  task automatic clear_obs();
    exp_q.delete(); exp_kind_q.delete();
    beat_addr_q.delete(); beat_kind_q.delete(); beat_cyc_q.delete(); beat_ok_q.delete();
    done_side_q.delete(); done_cyc_q.delete();
    spur = 0;
    dc_extra = 0;
  endtask

  // ---------------- driver ----------------
  // ack_mode: 0 always, 1 alternate starting low, 2 random.
  // Drops requests on their done pulse (D re-requests while dc_extra > 0),
  // optionally withdraws dc_req during beat drop_beat. Returns when all is idle.
  task automatic drive_run(input int ack_mode, input int max_cyc, input int drop_beat,
                           output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk); #1;
      if (ic_done) ic_req = 1'b0;
      if (dc_done) begin
        if (dc_extra > 0) dc_extra--;
        else dc_req = 1'b0;
      end
      if (drop_beat >= 0 && mem_req && beat_addr_q.size() == drop_beat) dc_req = 1'b0;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (k % 2) == 1;
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
      mem_rdata = $urandom;
      dc_wdata  = $urandom;
      if (!ic_req && !dc_req && !mem_req && !ic_done && !dc_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom; dc_wdata = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done} !== 7'd0)
      $display("FAIL reset_flags: got %b want 0000000",
               {mem_req, mem_we, ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done});
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0) $display("FAIL reset_addr: got %h want 0", mem_addr);
    else n_pass++;
    n_checks++;
    if (ic_rdata !== mem_rdata || dc_rdata !== mem_rdata)
      $display("FAIL reset_rdata: got %h/%h want %h", ic_rdata, dc_rdata, mem_rdata);
    else n_pass++;
    rst_n = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0) $display("FAIL idle_no_req: mem_req %b want 0", mem_req);
    else n_pass++;
  endtask

  task automatic test_i_refill();
    bit to; int raise_cyc;
    clear_obs();
    ic_addr = 32'h0000_1044;
    model_line(1'b0, 1'b0, ic_addr);
    @(posedge clk); #1;
    raise_cyc = cyc + 1;
    ic_req = 1'b1;
    drive_run(0, 40, -1, to);
    n_checks++;
    if (to || beat_addr_q.size() != LW) $display("FAIL i_refill_len: timeout %0d beats %0d want 0 %0d", to, beat_addr_q.size(), LW);
    else n_pass++;
    for (int k = 0; k < LW && k < beat_addr_q.size(); k++) begin
      n_checks++;
      if (beat_addr_q[k] !== exp_q[k] || beat_kind_q[k] !== exp_kind_q[k] || !beat_ok_q[k] ||
          beat_cyc_q[k] != raise_cyc + 1 + k)
        $display("FAIL i_beat%0d: addr %h kind %0d ok %0d cyc %0d want %h %0d 1 %0d", k,
                 beat_addr_q[k], beat_kind_q[k], beat_ok_q[k], beat_cyc_q[k], exp_q[k], exp_kind_q[k], raise_cyc + 1 + k);
      else n_pass++;
    end
    n_checks++;
    if (done_side_q.size() != 1 || done_side_q[0] !== 1'b0 || done_cyc_q[0] != raise_cyc + LW + 1 || spur != 0)
      $display("FAIL i_done: count %0d cyc %0d spur %0d want 1 at %0d spur 0", done_side_q.size(),
               done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, spur, raise_cyc + LW + 1);
    else n_pass++;
  endtask

  task automatic test_d_writeback();
    bit to; int raise_cyc;
    clear_obs();
    dc_addr = $urandom; dc_we = 1'b1;
    model_line(1'b1, 1'b1, dc_addr);
    @(posedge clk); #1;
    raise_cyc = cyc + 1;
    dc_req = 1'b1;
    drive_run(1, 60, -1, to);
    n_checks++;
    if (to || beat_addr_q.size() != LW) $display("FAIL wb_len: timeout %0d beats %0d want 0 %0d", to, beat_addr_q.size(), LW);
    else n_pass++;
    for (int k = 0; k < LW && k < beat_addr_q.size(); k++) begin
      n_checks++;
      if (beat_addr_q[k] !== exp_q[k] || beat_kind_q[k] !== exp_kind_q[k] || !beat_ok_q[k] ||
          beat_cyc_q[k] != raise_cyc + 2 + 2 * k)
        $display("FAIL wb_beat%0d: addr %h kind %0d ok %0d cyc %0d want %h %0d 1 %0d", k,
                 beat_addr_q[k], beat_kind_q[k], beat_ok_q[k], beat_cyc_q[k], exp_q[k], exp_kind_q[k], raise_cyc + 2 + 2 * k);
      else n_pass++;
    end
    n_checks++;
    if (done_side_q.size() != 1 || done_side_q[0] !== 1'b1 || done_cyc_q[0] != raise_cyc + 2 * LW + 1 || spur != 0)
      $display("FAIL wb_done: count %0d spur %0d want 1 D-side at %0d spur 0", done_side_q.size(), spur, raise_cyc + 2 * LW + 1);
    else n_pass++;
    dc_we = 1'b0;
  endtask

  task automatic test_tie();
    bit to; bit pend_i; int rem_d; bit last_d; bit w; bit order_q[$];
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    ic_addr = $urandom; dc_addr = $urandom; dc_we = 1'b0;
    pend_i = 1'b1; rem_d = 3; last_d = 1'b0;
    while (pend_i || rem_d > 0) begin
      w = arb_d(pend_i, rem_d > 0, last_d);
      order_q.push_back(w);
      if (w) begin rem_d--; model_line(1'b1, 1'b0, dc_addr); end
      else begin pend_i = 1'b0; model_line(1'b0, 1'b0, ic_addr); end
      last_d = w;
    end
    @(posedge clk); #1;
    ic_req = 1'b1; dc_req = 1'b1; dc_extra = 2;
    drive_run(0, 200, -1, to);
    n_checks++;
    if (to || done_side_q.size() != order_q.size())
      $display("FAIL tie_len: timeout %0d dones %0d want 0 %0d", to, done_side_q.size(), order_q.size());
    else n_pass++;
    for (int k = 0; k < order_q.size() && k < done_side_q.size(); k++) begin
      n_checks++;
      if (done_side_q[k] !== order_q[k]) $display("FAIL tie_order%0d: side %0d want %0d", k, done_side_q[k], order_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (beat_addr_q.size() != exp_q.size()) $display("FAIL tie_beats: got %0d want %0d", beat_addr_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < beat_addr_q.size(); k++) begin
      n_checks++;
      if (beat_addr_q[k] !== exp_q[k] || beat_kind_q[k] !== exp_kind_q[k] || !beat_ok_q[k])
        $display("FAIL tie_beat%0d: addr %h kind %0d ok %0d want %h %0d", k, beat_addr_q[k], beat_kind_q[k], beat_ok_q[k], exp_q[k], exp_kind_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_withdraw();
    bit to;
    clear_obs();
    dc_addr = $urandom; dc_we = 1'b0;
    model_line(1'b1, 1'b0, dc_addr);
    @(posedge clk); #1;
    dc_req = 1'b1;
    drive_run(0, 40, 2, to);
    n_checks++;
    if (to || beat_addr_q.size() != LW || done_side_q.size() != 1 || done_side_q[0] !== 1'b1)
      $display("FAIL withdraw: timeout %0d beats %0d dones %0d want 0 %0d 1", to, beat_addr_q.size(), done_side_q.size(), LW);
    else n_pass++;
    for (int k = 0; k < LW && k < beat_addr_q.size(); k++) begin
      n_checks++;
      if (beat_addr_q[k] !== exp_q[k] || beat_kind_q[k] !== exp_kind_q[k] || !beat_ok_q[k])
        $display("FAIL withdraw_beat%0d: addr %h kind %0d want %h %0d", k, beat_addr_q[k], beat_kind_q[k], exp_q[k], exp_kind_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit to; int raise_cyc; int stall_bad;
    clear_obs();
    ic_addr = $urandom;
    model_line(1'b0, 1'b0, ic_addr);
    @(posedge clk); #1;
    raise_cyc = cyc + 1;
    ic_req = 1'b1; mem_ack = 1'b0;
    stall_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req !== 1'b1 || mem_addr !== line_base(ic_addr) || mem_we !== 1'b0 ||
          ic_rvalid || dc_rvalid || dc_wready || ic_done || dc_done) stall_bad++;
    end
    n_checks++;
    if (stall_bad != 0) $display("FAIL stall_hold: %0d bad cycles want 0", stall_bad);
    else n_pass++;
    drive_run(0, 40, -1, to);
    n_checks++;
    if (to || beat_addr_q.size() != LW || beat_cyc_q[0] != raise_cyc + 21)
      $display("FAIL stall_resume: timeout %0d beats %0d first %0d want 0 %0d %0d", to, beat_addr_q.size(),
               beat_cyc_q.size() > 0 ? beat_cyc_q[0] : -1, LW, raise_cyc + 21);
    else n_pass++;
    n_checks++;
    if (done_side_q.size() != 1 || spur != 0) $display("FAIL stall_done: dones %0d spur %0d want 1 0", done_side_q.size(), spur);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_obs();
    ic_addr = $urandom;
    @(posedge clk); #1;
    ic_req = 1'b1; mem_ack = 1'b1;
    for (int k = 0; k < 20 && beat_addr_q.size() < 4; k++) begin
      @(posedge clk); #1;
      mem_rdata = $urandom;
    end
    n_checks++;
    if (beat_addr_q.size() != 4) $display("FAIL rstmid_reach: beats %0d want 4", beat_addr_q.size());
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || ic_rvalid !== 1'b0) $display("FAIL rstmid_async: mem_req %b rvalid %b want 0 0", mem_req, ic_rvalid);
    else n_pass++;
    ic_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_side_q.size() != 0 || beat_addr_q.size() != 4)
      $display("FAIL rstmid_abandon: dones %0d beats %0d want 0 4", done_side_q.size(), beat_addr_q.size());
    else n_pass++;
    clear_obs();
    ic_addr = $urandom;
    model_line(1'b0, 1'b0, ic_addr);
    @(posedge clk); #1;
    ic_req = 1'b1;
    drive_run(0, 40, -1, to);
    n_checks++;
    if (to || beat_addr_q.size() != LW || done_side_q.size() != 1 || done_side_q[0] !== 1'b0)
      $display("FAIL rstmid_after: timeout %0d beats %0d dones %0d want 0 %0d 1", to, beat_addr_q.size(), done_side_q.size(), LW);
    else n_pass++;
    for (int k = 0; k < LW && k < beat_addr_q.size(); k++) begin
      n_checks++;
      if (beat_addr_q[k] !== exp_q[k] || beat_kind_q[k] !== exp_kind_q[k])
        $display("FAIL rstmid_beat%0d: addr %h kind %0d want %h %0d", k, beat_addr_q[k], beat_kind_q[k], exp_q[k], exp_kind_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit to; bit side_d; bit we;
    for (int n = 0; n < 6; n++) begin
      clear_obs();
      side_d = 1'($urandom_range(0, 1));
      we     = side_d ? 1'($urandom_range(0, 1)) : 1'b0;
      ic_addr = $urandom; dc_addr = $urandom; dc_we = we;
      model_line(side_d, we, side_d ? dc_addr : ic_addr);
      @(posedge clk); #1;
      if (side_d) dc_req = 1'b1; else ic_req = 1'b1;
      drive_run(2, 300, -1, to);
      n_checks++;
      if (to || beat_addr_q.size() != LW || done_side_q.size() != 1 || done_side_q[0] !== side_d || spur != 0)
        $display("FAIL rand%0d_line: timeout %0d beats %0d dones %0d spur %0d want 0 %0d 1 0", n, to,
                 beat_addr_q.size(), done_side_q.size(), spur, LW);
      else n_pass++;
      for (int k = 0; k < LW && k < beat_addr_q.size(); k++) begin
        n_checks++;
        if (beat_addr_q[k] !== exp_q[k] || beat_kind_q[k] !== exp_kind_q[k] || !beat_ok_q[k])
          $display("FAIL rand%0d_beat%0d: addr %h kind %0d ok %0d want %h %0d", n, k,
                   beat_addr_q[k], beat_kind_q[k], beat_ok_q[k], exp_q[k], exp_kind_q[k]);
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_pass = 0; dc_extra = 0;
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    test_reset();
    test_i_refill();
    test_d_writeback();
    test_tie();
    test_withdraw();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Sequences cache-line transfers between the instruction-side and data-side cache controllers and the single shared main-memory port. It sits between the pipeline's I/D cache miss handlers and the memory bus. It grants one requester at a time, generates per-beat line addresses, and returns per-beat read data or write acceptance. It signals completion so each cache can release its pipeline stall.

## Interface
- LINE_WORDS, 8: words per cache line; power of two, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: beat data width.

- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ic_req  in  1  I-side line read request; held until ic_done.
- ic_addr  in  ADDR_W  I-side line address; offset bits ignored.
- ic_rdata  out  DATA_W  read beat data.
- ic_rvalid  out  1  ic_rdata valid this cycle.
- ic_done  out  1  one-cycle pulse, transfer complete.
- dc_req  in  1  D-side line request; held until dc_done.
- dc_we  in  1  1 = writeback, 0 = refill; sampled at grant.
- dc_addr  in  ADDR_W  D-side line address; offset bits ignored.
- dc_wdata  in  DATA_W  current writeback beat.
- dc_wready  out  1  dc_wdata consumed this cycle; requester advances to the next word.
- dc_rdata  out  DATA_W  read beat data.
- dc_rvalid  out  1  dc_rdata valid this cycle.
- dc_done  out  1  one-cycle pulse, transfer complete.
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat word address.
- mem_wdata  out  DATA_W  write data; equals dc_wdata.
- mem_rdata  in  DATA_W  read data; valid when mem_ack is high and mem_we is 0.
- mem_ack  in  1  beat completes this cycle.

## Operation
- States: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - Sample ic_req and dc_req.
  - Choose the winner per the arbitration policy.
  - Latch the line base (address with the low log2(LINE_WORDS)+2 bits zeroed) and, for D, dc_we.
  - Clear the beat counter.
  - Record last_grant.
- GRANT_x:
  - mem_req = 1.
  - mem_addr = base + 4·beat.
  - mem_we = latched we (0 for I).
  - On mem_ack: beat increments. ic_rvalid or dc_rvalid = mem_ack & ~we; dc_wready = mem_ack & we.
  - After the ack on beat LINE_WORDS−1, go to DONE.
- DONE: the granted side's done = 1 for one cycle; mem_req = 0; go to IDLE.
- Requests are sampled only in IDLE.
  - Dropping req mid-transfer is ignored; the full line still transfers.
  - A requester must hold req low in the cycle after its done pulse.
- ic_rdata and dc_rdata are wired directly to mem_rdata. The valid flags qualify them.
- The beat counter is log2(LINE_WORDS) bits and never wraps during a transfer.
- Reset values: state IDLE, counter 0, last_grant = I, all outputs 0 (rdata outputs follow mem_rdata).
- Reset mid-transfer:
  - mem_req drops immediately (asynchronously).
  - No done pulse is issued.
  - The transfer is abandoned.

## Timing
- Grant latency: a req sampled high in IDLE at cycle t gives mem_req = 1 from t+1.
- With mem_ack held high: beats occur at t+1 … t+LINE_WORDS and done is at t+LINE_WORDS+1. The next grant can start at t+LINE_WORDS+3.
- Wait states: each cycle with mem_req=1 and mem_ack=0 holds mem_addr, mem_we and the beat counter.
- Valid, wready and ack are combinational from mem_ack in the same cycle. There is no extra latency.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requests are high in IDLE, grant the side that is not last_grant.
  - Because last_grant resets to I, D wins the first tie.
- Not defined:
  - Fixed priority: D always wins a tie.
  - I can starve while D requests back-to-back.
  - last_grant is still maintained but unused.

## Test plan
- Single I refill:
  - Stimulus: LINE_WORDS=8, ic_addr=0x0000_1044, mem_ack=1 every cycle.
  - Required: mem_addr 0x1040…0x105C on t+1…t+8; eight ic_rvalid pulses; ic_done at t+9; mem_we=0 throughout.
- D writeback with wait states:
  - Stimulus: dc_we=1; mem_ack alternating 0/1.
  - Required: 8 beats over 16 cycles; dc_wready coincides with each ack; mem_we=1; dc_done once.
- Simultaneous requests after reset:
  - Required: D granted first in both builds.
  - With ARB_ROUND_ROBIN_EN and dc_req re-raised right after dc_done: grant order D, I, D.
  - Without the macro: I is not granted until dc_req stays low in IDLE.
- Reset mid-transfer:
  - Stimulus: pull rst_n low after beat 3 ack.
  - Required: mem_req 0 with no clock edge; no done; after release, a new ic_req completes a normal 8-beat transfer from beat 0.
- Request withdrawal: drop dc_req during beat 2; exactly 8 beats and a single dc_done still occur.
- Stalled memory: hold mem_ack=0 for 20 cycles on beat 0; mem_addr stays stable and no valid, wready or done is asserted.
